// File: rtl/video_mem_responder.sv
// video_mem_responder: bus-side responder for VRAM and OAM with mode-based
// lockout, PPU-port priority, and read-only PPU fetch ports.
module video_mem_responder #(
  parameter logic [15:0] VRAM_ADDR = 16'h8000,
  parameter int          VRAM_SIZE = 8192,
  parameter logic [15:0] OAM_LOC   = 16'hFE00,
  parameter int          OAM_SIZE  = 160,
  parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [7:0]  bus_rdata,
  output logic        bus_ack,
  input  logic [1:0]  ppu_mode,
  input  logic        ppu_vram_rd,
  input  logic [12:0] ppu_vram_addr,
  output logic [7:0]  ppu_vram_data,
  input  logic        ppu_oam_rd,
  input  logic [7:0]  ppu_oam_addr,
  output logic [7:0]  ppu_oam_data,
  output logic [15:0] drop_count
);

  localparam int VA_W = $clog2(VRAM_SIZE);
  localparam int OA_W = $clog2(OAM_SIZE);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, RELEASE} stateT;

  stateT curState, nextState;

  logic [7:0] vram [VRAM_SIZE];
  logic [7:0] oam  [OAM_SIZE];

  // Window decode; unsigned wrap of the subtraction makes a single compare enough.
  logic [15:0] vramOff, oamOff;
  logic        vramHit, oamHit, busHit;
  assign vramOff = bus_addr - VRAM_ADDR;
  assign oamOff  = bus_addr - OAM_LOC;
  assign vramHit = 32'(vramOff) < VRAM_SIZE;
  assign oamHit  = 32'(oamOff) < OAM_SIZE;
  assign busHit  = vramHit | oamHit;

  // Captured request.
  logic            reqWrite, reqVram;
  logic [VA_W-1:0] reqVramIdx;
  logic [OA_W-1:0] reqOamIdx;
  logic [7:0]      reqData;

  // PPU fetch indices wrap modulo the array size.
  logic [VA_W-1:0] ppuVramIdx;
  logic [OA_W-1:0] ppuOamIdx;
  assign ppuVramIdx = VA_W'(32'(ppu_vram_addr) % VRAM_SIZE);
  assign ppuOamIdx  = OA_W'(32'(ppu_oam_addr) % OAM_SIZE);

  logic locked, ppuConflict;
  assign locked      = (ppu_mode == 2'd3) || (ppu_mode == 2'd2 && !reqVram);
  assign ppuConflict = reqVram ? ppu_vram_rd : ppu_oam_rd;

  logic captureEn, doAccess, doLocked;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) curState <= IDLE;
    else          curState <= nextState;
  end

  // Next-state and control: lockout wins over contention, contention stalls.
  always_comb begin
    nextState = curState;
    captureEn = 1'b0;
    doAccess  = 1'b0;
    doLocked  = 1'b0;
    bus_ack   = 1'b0;
    case (curState)
      IDLE: begin
        if (busHit && (bus_re || bus_we)) begin
          captureEn = 1'b1;
          nextState = ACCESS;
        end
      end
      ACCESS: begin
        if (locked) begin
          doLocked  = 1'b1;
          nextState = RESP;
        end else if (!ppuConflict) begin
          doAccess  = 1'b1;
          nextState = RESP;
        end
      end
      RESP: begin
        bus_ack   = 1'b1;
        nextState = RELEASE;
      end
      RELEASE: begin
        if (!bus_re && !bus_we) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Request capture, read data return and dropped-write counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reqWrite   <= 1'b0;
      reqVram    <= 1'b0;
      reqVramIdx <= '0;
      reqOamIdx  <= '0;
      reqData    <= 8'h00;
      bus_rdata  <= OPEN_BUS;
      drop_count <= 16'h0000;
    end else begin
      if (captureEn) begin
        reqWrite   <= bus_we;
        reqVram    <= vramHit;
        reqVramIdx <= vramOff[VA_W-1:0];
        reqOamIdx  <= oamOff[OA_W-1:0];
        reqData    <= bus_wdata;
      end
      if (doLocked) begin
        if (reqWrite) begin
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end else begin
          bus_rdata <= OPEN_BUS;
        end
      end
      if (doAccess && !reqWrite)
        bus_rdata <= reqVram ? vram[reqVramIdx] : oam[reqOamIdx];
    end
  end

  // Array writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (doAccess && reqWrite) begin
      if (reqVram) vram[reqVramIdx] <= reqData;
      else         oam[reqOamIdx]   <= reqData;
    end
  end

  // PPU fetch ports: registered, never locked, hold value without a strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ppu_vram_data <= 8'h00;
      ppu_oam_data  <= 8'h00;
    end else begin
      if (ppu_vram_rd) ppu_vram_data <= vram[ppuVramIdx];
      if (ppu_oam_rd)  ppu_oam_data  <= oam[ppuOamIdx];
    end
  end

endmodule
